// File: rtl/mux_n_reg.sv
// Registered N-to-1 datapath select with valid/hold handshake.
// Out-of-range selects leave dout untouched, drop out_valid, and are
// recorded in a sticky flag plus a saturating counter.
module mux_n_reg #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*WIDTH-1:0]  din,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  input  logic                     hold,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     out_valid,
  output logic                     sel_err,
  output logic [CNT_W-1:0]         err_cnt
);

  localparam int unsigned SEL_SPAN = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Parameter legality is checked at elaboration.
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("mux_n_reg: NUM_IN must be in 2..16");
  end
  if (SEL_SPAN < NUM_IN) begin : g_bad_sel_w
    $error("mux_n_reg: SEL_W too narrow for NUM_IN");
  end

  logic [WIDTH-1:0] r_dout;
  logic             r_out_valid;
  logic             r_sel_err;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_in_range;
  logic             w_accept;
  logic             w_err_evt;
  logic             w_cnt_sat;

  // A full select space has no out-of-range codes; avoid a constant compare.
  if (NUM_IN == SEL_SPAN) begin : g_full_span
    assign w_in_range = 1'b1;
  end else begin : g_partial_span
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);
    assign w_in_range = ({1'b0, sel} < NUM_IN_L);
  end

  // Select the addressed slice; out-of-range codes fall through to zero and are never loaded.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  // A request is consumed only when not stalled.
  assign w_accept  = in_valid & ~hold;
  assign w_err_evt = w_accept & ~w_in_range;
  assign w_cnt_sat = (r_err_cnt == CNT_MAX);

  // Output data register and valid pulse; both freeze under hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else if (!hold) begin
      if (in_valid && w_in_range) begin
        r_dout      <= w_sel_data;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Sticky error flag; a fresh error beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_err_evt) begin
      r_sel_err <= 1'b1;
    end else if (clr_err) begin
      r_sel_err <= 1'b0;
    end
  end

  // Saturating error counter; clear plus new error restarts at one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (clr_err) begin
      r_err_cnt <= w_err_evt ? CNT_W'(1) : '0;
    end else if (w_err_evt && !w_cnt_sat) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: default 16-bit/3-input instance plus an
// 8-bit/4-input instance, each checked every cycle against a behavioural model.
module tb_mux_n_reg;

  logic clk;
  logic reset;

  // Default instance stimulus
  logic [15:0] din_a [3];
  logic [47:0] din_flat;
  logic [1:0]  sel;
  logic        in_valid, hold, clr_err;
  logic [15:0] dout;
  logic        out_valid, sel_err;
  logic [7:0]  err_cnt;

  // 8-bit, 4-input instance stimulus
  logic [7:0]  din_b [4];
  logic [31:0] din_flat_b;
  logic [1:0]  sel_b;
  logic        in_valid_b;
  logic [7:0]  dout_b;
  logic        out_valid_b, sel_err_b;
  logic [7:0]  err_cnt_b;

  int checks;
  int failures;

  always_comb begin
    din_flat   = {din_a[2], din_a[1], din_a[0]};
    din_flat_b = {din_b[3], din_b[2], din_b[1], din_b[0]};
  end

  mux_n_reg u_dut (
    .clk(clk), .reset(reset), .din(din_flat), .sel(sel),
    .in_valid(in_valid), .hold(hold), .clr_err(clr_err),
    .dout(dout), .out_valid(out_valid), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  mux_n_reg #(.WIDTH(8), .NUM_IN(4), .SEL_W(2), .CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .din(din_flat_b), .sel(sel_b),
    .in_valid(in_valid_b), .hold(1'b0), .clr_err(1'b0),
    .dout(dout_b), .out_valid(out_valid_b), .sel_err(sel_err_b), .err_cnt(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what each output must be after every edge.
  int m_dout, m_ov, m_err, m_cnt;
  int m_dout_b, m_ov_b, m_err_b, m_cnt_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dout <= 0; m_ov <= 0; m_err <= 0; m_cnt <= 0;
    end else begin
      bit stalled, legal, bad;
      stalled = (hold === 1'b1);
      legal   = (int'(sel) < 3);
      bad     = !stalled && in_valid && !legal;
      if (!stalled) begin
        if (in_valid && legal) m_dout <= int'(din_a[sel]);
        m_ov <= (in_valid && legal) ? 1 : 0;
      end
      if (bad) begin
        m_err <= 1;
        m_cnt <= clr_err ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
      end else if (clr_err) begin
        m_err <= 0;
        m_cnt <= 0;
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dout_b <= 0; m_ov_b <= 0; m_err_b <= 0; m_cnt_b <= 0;
    end else begin
      // Four inputs on a 2-bit select: every code is legal.
      if (in_valid_b) m_dout_b <= int'(din_b[sel_b]);
      m_ov_b <= in_valid_b ? 1 : 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_dout",      int'(dout),        m_dout);
    chk("cyc_out_valid", int'(out_valid),   m_ov);
    chk("cyc_sel_err",   int'(sel_err),     m_err);
    chk("cyc_err_cnt",   int'(err_cnt),     m_cnt);
    chk("cyc_dout_b",    int'(dout_b),      m_dout_b);
    chk("cyc_ov_b",      int'(out_valid_b), m_ov_b);
    chk("cyc_err_b",     int'(sel_err_b),   m_err_b);
    chk("cyc_cnt_b",     int'(err_cnt_b),   m_cnt_b);
  end

  // Advance one edge; inputs change 1 time unit after it.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    din_a[0] = 16'h0000; din_a[1] = 16'h1111; din_a[2] = 16'h2222;
    for (int k = 0; k < 4; k++) din_b[k] = 8'(8'h10 + k);
    sel = 2'd0; in_valid = 1'b1; hold = 1'b0; clr_err = 1'b0;
    sel_b = 2'd0; in_valid_b = 1'b0;
    tick(2);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ov",   int'(out_valid), 0);
    chk("rst_err",  int'(sel_err), 0);
    chk("rst_cnt",  int'(err_cnt), 0);
    reset = 1'b0;

    // Back-to-back selects, one result per cycle.
    din_a[0] = 16'h1234; din_a[1] = 16'hABCD; din_a[2] = 16'h0F0F;
    sel = 2'd0; in_valid = 1'b1;
    tick(); chk("b2b_0", int'(dout), 'h1234); chk("b2b_ov0", int'(out_valid), 1);
    sel = 2'd1;
    tick(); chk("b2b_1", int'(dout), 'hABCD); chk("b2b_ov1", int'(out_valid), 1);
    sel = 2'd2;
    tick(); chk("b2b_2", int'(dout), 'h0F0F); chk("b2b_ov2", int'(out_valid), 1);

    // Out-of-range select holds dout and counts, saturating at 255.
    sel = 2'd1; tick();
    sel = 2'd3; tick();
    chk("oor_dout", int'(dout), 'hABCD);
    chk("oor_ov",   int'(out_valid), 0);
    chk("oor_err",  int'(sel_err), 1);
    chk("oor_cnt",  int'(err_cnt), 1);
    tick(299);
    chk("sat_cnt",  int'(err_cnt), 255);
    chk("sat_dout", int'(dout), 'hABCD);

    // Clear alone, then clear racing a new error.
    in_valid = 1'b0; clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr0_err", int'(sel_err), 0); chk("clr0_cnt", int'(err_cnt), 0);
    in_valid = 1'b1; sel = 2'd3; tick(5);
    chk("five_cnt", int'(err_cnt), 5);
    in_valid = 1'b0; clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_err", int'(sel_err), 0); chk("clr_cnt", int'(err_cnt), 0);
    in_valid = 1'b1; sel = 2'd3; tick(5);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clrnew_err", int'(sel_err), 1); chk("clrnew_cnt", int'(err_cnt), 1);

    // Hold freezes outputs and does not count errors.
    sel = 2'd2; tick();
    chk("pre_hold", int'(dout), 'h0F0F);
    hold = 1'b1; sel = 2'd1; tick(3);
    chk("hold_dout", int'(dout), 'h0F0F);
    chk("hold_ov",   int'(out_valid), 1);
    sel = 2'd3; tick();
    chk("hold_nocnt", int'(err_cnt), 1);
    sel = 2'd1; hold = 1'b0; tick();
    chk("unhold_dout", int'(dout), 'hABCD);
    chk("unhold_ov",   int'(out_valid), 1);

    // Clear applies while stalled.
    hold = 1'b1; clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("hclr_err", int'(sel_err), 0); chk("hclr_cnt", int'(err_cnt), 0);
    hold = 1'b0; in_valid = 1'b0; tick();
    chk("idle_ov", int'(out_valid), 0); chk("idle_dout", int'(dout), 'hABCD);

    // 8-bit, 4-input sweep: every code legal, no errors.
    in_valid_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel_b = 2'(k);
      tick();
      chk("sweep_dout", int'(dout_b), 'h10 + k);
      chk("sweep_err",  int'(sel_err_b), 0);
    end
    in_valid_b = 1'b0;

    // Mid-cycle reset clears immediately; first request after it valid one edge later.
    in_valid = 1'b1; sel = 2'd0; tick();
    #2 reset = 1'b1;
    #1 chk("async_dout", int'(dout), 0); chk("async_ov", int'(out_valid), 0);
    @(posedge clk); #1 reset = 1'b0;
    sel = 2'd2; tick();
    chk("post_rst_ov", int'(out_valid), 1); chk("post_rst_dout", int'(dout), 'h0F0F);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
